// File: rtl/booth_pp_accum_if.sv
// Handshake bundle between the Booth partial-product stage and its accumulator.
// The master drives the digits and consumes the product; the slave accumulates them.
interface booth_pp_accum_if #(
  parameter int W = 8
);
  logic           clr;
  logic           in_valid;
  logic           in_ready;
  logic [W:0]     pp;
  logic           cpl;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  modport master (
    output clr, in_valid, pp, cpl, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  clr, in_valid, pp, cpl, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_pp_accum.sv
// Sequential back end of a radix-4 Booth multiplier: sums W/2 weighted digits,
// LSB digit first, and presents the 2W-bit signed product on a valid/ready port.
module booth_pp_accum #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  booth_pp_accum_if.slave bus
);
  localparam int N  = W / 2;
  localparam int CW = $clog2(N);
  localparam int AW = 2 * W + 2;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [AW-1:0]  acc_reg;
  logic [2*W-1:0] product_reg;
  logic           out_valid_reg;

  logic [W+1:0]   digit;
  logic [AW-1:0]  term;
  logic [AW-1:0]  acc_sum;
  logic           accept;

  // pp is one's-complemented for negative digits; cpl completes the negation.
  assign digit   = {bus.pp[W], bus.pp} + {{(W+1){1'b0}}, bus.cpl};
  assign term    = {{(AW-W-2){digit[W+1]}}, digit} << {cnt_reg, 1'b0};
  assign acc_sum = acc_reg + term;

  assign bus.in_ready  = !bus.clr && ((state_reg != DONE) || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.product   = product_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      product_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else if (bus.clr) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACC: begin
          if (accept) begin
            if (cnt_reg == CW'(N - 1)) begin
              state_reg     <= DONE;
              cnt_reg       <= '0;
              acc_reg       <= acc_sum;
              product_reg   <= acc_sum[2*W-1:0];
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= ACC;
              cnt_reg   <= cnt_reg + CW'(1);
              acc_reg   <= acc_sum;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            // cnt_reg is zero here, so term is the unshifted first digit.
            if (accept) begin
              state_reg <= ACC;
              cnt_reg   <= CW'(1);
              acc_reg   <= term;
            end else begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
              acc_reg   <= '0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          acc_reg       <= '0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_pp_accum.sv
// Directed and randomized checks of booth_pp_accum at W=8 against hand-computed
// vectors and a golden x*y model.
module tb_booth_pp_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  booth_pp_accum_if #(.W(8)) bus ();

  booth_pp_accum #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one digit from the negedge; returns #1 after the edge that accepts it.
  task automatic send(input logic [8:0] p, input logic c);
    int t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.pp       = p;
    bus.cpl      = c;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Upstream model: radix-4 Booth recoding of x, multiplicand y.
  task automatic send_xy(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] xe;
    logic [2:0] trip;
    logic [8:0] v;
    xe = {x, 1'b0};
    for (int i = 0; i < 4; i++) begin
      trip = xe[2*i +: 3];
      case (trip)
        3'b001, 3'b010: send({y[7], y}, 1'b0);
        3'b011:         send({y, 1'b0}, 1'b0);
        3'b100: begin v = {y, 1'b0};  send(~v, 1'b1); end
        3'b101, 3'b110: begin v = {y[7], y}; send(~v, 1'b1); end
        default:        send(9'h000, 1'b0);
      endcase
    end
  endtask

  initial begin
    logic [7:0]  rx, ry;
    logic [15:0] gold;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.pp = '0; bus.cpl = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_product", bus.product, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // T1 basic 3*5
    send(9'h1FA, 1'b1); send(9'h005, 1'b0); send(9'h000, 1'b0);
    check("t1_valid_before_last", bus.out_valid, 1'b0);
    send(9'h000, 1'b0);
    check("t1_out_valid", bus.out_valid, 1'b1);
    check("t1_product", bus.product, 16'h000F);
    $display("T1 product=%h", bus.product);

    // T3 stall with out_ready low
    @(negedge clk); bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      check("t3_out_valid", bus.out_valid, 1'b1);
      check("t3_product", bus.product, 16'h000F);
      check("t3_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_consumed", bus.out_valid, 1'b0);
    $display("T3 stall held product=%h", bus.product);

    // T2 corner -128*-128
    bus.out_ready = 1'b0;
    send(9'h000, 1'b0); send(9'h000, 1'b0); send(9'h000, 1'b0); send(9'h0FF, 1'b1);
    check("t2_out_valid", bus.out_valid, 1'b1);
    check("t2_product", bus.product, 16'h4000);
    $display("T2 product=%h", bus.product);
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // T4 back-to-back 3*5 then -1*7
    send(9'h1FA, 1'b1); send(9'h005, 1'b0); send(9'h000, 1'b0); send(9'h000, 1'b0);
    check("t4_first_valid", bus.out_valid, 1'b1);
    check("t4_first_product", bus.product, 16'h000F);
    send(9'h1F8, 1'b1);
    check("t4_valid_dropped", bus.out_valid, 1'b0);
    send(9'h000, 1'b0); send(9'h000, 1'b0); send(9'h000, 1'b0);
    check("t4_second_valid", bus.out_valid, 1'b1);
    check("t4_second_product", bus.product, 16'hFFF9);
    $display("T4 products 000F then %h", bus.product);
    idle_cycle();

    // T5 abort after two digits
    send(9'h1FA, 1'b1); send(9'h005, 1'b0);
    @(negedge clk);
    bus.clr = 1'b1; bus.in_valid = 1'b1; bus.pp = 9'h005; bus.cpl = 1'b0;
    #1;
    check("t5_in_ready_clr", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    check("t5_valid_after_clr", bus.out_valid, 1'b0);
    @(negedge clk); bus.clr = 1'b0; bus.in_valid = 1'b0;
    send(9'h1FA, 1'b1); send(9'h005, 1'b0); send(9'h000, 1'b0); send(9'h000, 1'b0);
    check("t5_out_valid", bus.out_valid, 1'b1);
    check("t5_product", bus.product, 16'h000F);
    $display("T5 product=%h", bus.product);
    idle_cycle();

    // T6 asynchronous reset mid-product
    send(9'h1FA, 1'b1); send(9'h005, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_out_valid", bus.out_valid, 1'b0);
    check("t6_product", bus.product, 16'h0000);
    @(negedge clk); rst = 1'b0;
    send(9'h000, 1'b0); send(9'h000, 1'b0); send(9'h000, 1'b0); send(9'h0FF, 1'b1);
    check("t6_t2_product", bus.product, 16'h4000);
    $display("T6 post-reset product=%h", bus.product);
    idle_cycle();

    // Random signed pairs, back-to-back
    for (int k = 0; k < 1000; k++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      gold = 16'($signed(rx) * $signed(ry));
      send_xy(rx, ry);
      check("rand_valid", bus.out_valid, 1'b1);
      check("rand_product", bus.product, gold);
      $display("rand x=%h y=%h product=%h", rx, ry, bus.product);
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
